// File: rtl/if_id_stage.sv
// IF/ID pipeline register. It captures the fetched PC and instruction, drives the
// PC write-enable, tags bad fetch addresses with an address-error exception,
// turns flushes into bubbles and keeps saturating fetch performance counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT  = 32'h0000_6FFC,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [4:0]  EXC_ADEL  = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_instr,
  input  logic        if_bd,
  output logic        pc_en,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        id_valid,
  output logic [4:0]  id_excode,
  output logic        id_bd,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] fault_cnt
);

  // Increment that sticks at all-ones instead of wrapping to zero.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  logic        fault_s;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;
  logic [4:0]  id_excode_q, id_excode_d;
  logic        id_bd_q, id_bd_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] fault_cnt_q, fault_cnt_d;

  // A flush redirects the PC, so it must open the PC register even while stalled.
  assign pc_en = ~stall | flush;

  // Fetch address is bad when misaligned or outside the instruction memory window.
  assign fault_s = (if_pc[1:0] != 2'b00) | (if_pc < IM_BASE) | (if_pc > IM_LIMIT);

  // Next-state selection with priority flush > stall > load (reset handled in the flop).
  always_comb begin
    id_pc_d     = id_pc_q;
    id_instr_d  = id_instr_q;
    id_valid_d  = id_valid_q;
    id_excode_d = id_excode_q;
    id_bd_d     = id_bd_q;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    fault_cnt_d = fault_cnt_q;
    if (flush) begin
      id_pc_d     = if_pc;
      id_instr_d  = NOP_INSTR;
      id_valid_d  = 1'b0;
      id_excode_d = 5'd0;
      id_bd_d     = 1'b0;
    end else if (stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end else if (fault_s) begin
      // if_instr is never looked at here, so an X from a bad address cannot propagate.
      id_pc_d     = if_pc;
      id_instr_d  = NOP_INSTR;
      id_valid_d  = 1'b1;
      id_excode_d = EXC_ADEL;
      id_bd_d     = if_bd;
      fault_cnt_d = sat_inc(fault_cnt_q);
    end else begin
      id_pc_d     = if_pc;
      id_instr_d  = if_instr;
      id_valid_d  = 1'b1;
      id_excode_d = 5'd0;
      id_bd_d     = if_bd;
      fetch_cnt_d = sat_inc(fetch_cnt_q);
    end
  end

  // Pipeline and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_pc_q     <= RESET_PC;
      id_instr_q  <= NOP_INSTR;
      id_valid_q  <= 1'b0;
      id_excode_q <= 5'd0;
      id_bd_q     <= 1'b0;
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
      fault_cnt_q <= 32'd0;
    end else begin
      id_pc_q     <= id_pc_d;
      id_instr_q  <= id_instr_d;
      id_valid_q  <= id_valid_d;
      id_excode_q <= id_excode_d;
      id_bd_q     <= id_bd_d;
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign id_pc     = id_pc_q;
  assign id_instr  = id_instr_q;
  assign id_valid  = id_valid_q;
  assign id_excode = id_excode_q;
  assign id_bd     = id_bd_q;
  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
  assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage. The driver applies one vector per cycle and
// queues the hand-computed state expected after the following clock edge; a
// separate monitor pops and compares after every edge.
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_bd;
  logic        pc_en;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        id_valid;
  logic [4:0]  id_excode;
  logic        id_bd;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] fault_cnt;

  typedef struct {
    int          idx;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [4:0]  exc;
    logic        bd;
    logic [31:0] fc;
    logic [31:0] sc;
    logic [31:0] flc;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   failures;
  int   vec_no;

  if_id_stage dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .flush     (flush),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .if_bd     (if_bd),
    .pc_en     (pc_en),
    .id_pc     (id_pc),
    .id_instr  (id_instr),
    .id_valid  (id_valid),
    .id_excode (id_excode),
    .id_bd     (id_bd),
    .fetch_cnt (fetch_cnt),
    .stall_cnt (stall_cnt),
    .fault_cnt (fault_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] expv);
    checks = checks + 1;
    if (act !== expv) begin
      failures = failures + 1;
      $display("FAIL %s vec=%0d actual=%h expected=%h", name, idx, act, expv);
    end
  endtask

  // Drive one vector at the falling edge, check pc_en, queue the post-edge expectation.
  task automatic vec(input logic r, input logic s, input logic f,
                     input logic [31:0] pc, input logic [31:0] instr, input logic bd,
                     input logic e_pc_en,
                     input logic [31:0] e_pc, input logic [31:0] e_instr, input logic e_valid,
                     input logic [4:0] e_exc, input logic e_bd,
                     input logic [31:0] e_fc, input logic [31:0] e_sc, input logic [31:0] e_flc);
    exp_t e;
    @(negedge clk);
    reset    = r;
    stall    = s;
    flush    = f;
    if_pc    = pc;
    if_instr = instr;
    if_bd    = bd;
    vec_no   = vec_no + 1;
    #1;
    check("pc_en", vec_no, {31'd0, pc_en}, {31'd0, e_pc_en});
    e.idx = vec_no; e.pc = e_pc; e.instr = e_instr; e.valid = e_valid;
    e.exc = e_exc;  e.bd = e_bd; e.fc = e_fc; e.sc = e_sc; e.flc = e_flc;
    exp_q.push_back(e);
  endtask

  // Monitor: after each rising edge compare the registered outputs to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("id_pc",     e.idx, id_pc,              e.pc);
        check("id_instr",  e.idx, id_instr,           e.instr);
        check("id_valid",  e.idx, {31'd0, id_valid},  {31'd0, e.valid});
        check("id_excode", e.idx, {27'd0, id_excode}, {27'd0, e.exc});
        check("id_bd",     e.idx, {31'd0, id_bd},     {31'd0, e.bd});
        check("fetch_cnt", e.idx, fetch_cnt,          e.fc);
        check("stall_cnt", e.idx, stall_cnt,          e.sc);
        check("fault_cnt", e.idx, fault_cnt,          e.flc);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    vec_no   = 0;
    reset    = 1'b1;
    stall    = 1'b0;
    flush    = 1'b0;
    if_pc    = 32'h0000_3000;
    if_instr = 32'h2401_0005;
    if_bd    = 1'b0;

    //   rst   stl   fls   if_pc          if_instr       bd    pc_en  id_pc          id_instr       vld   exc    bd    fetch   stall   fault
    vec(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h2401_0005, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    vec(1'b1, 1'b0, 1'b0, 32'h0000_3000, 32'h2401_0005, 1'b0, 1'b1, 32'h0000_3000, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    vec(1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h2401_0005, 1'b0, 1'b1, 32'h0000_3000, 32'h2401_0005, 1'b1, 5'd0, 1'b0, 32'd1, 32'd0, 32'd0);
    vec(1'b0, 1'b0, 1'b0, 32'h0000_3004, 32'h8C22_0000, 1'b0, 1'b1, 32'h0000_3004, 32'h8C22_0000, 1'b1, 5'd0, 1'b0, 32'd2, 32'd0, 32'd0);
    // three stalled cycles: ID holds 3004
    vec(1'b0, 1'b1, 1'b0, 32'h0000_3008, 32'h1111_1111, 1'b1, 1'b0, 32'h0000_3004, 32'h8C22_0000, 1'b1, 5'd0, 1'b0, 32'd2, 32'd1, 32'd0);
    vec(1'b0, 1'b1, 1'b0, 32'h0000_3008, 32'h1111_1111, 1'b1, 1'b0, 32'h0000_3004, 32'h8C22_0000, 1'b1, 5'd0, 1'b0, 32'd2, 32'd2, 32'd0);
    vec(1'b0, 1'b1, 1'b0, 32'h0000_3008, 32'h1111_1111, 1'b1, 1'b0, 32'h0000_3004, 32'h8C22_0000, 1'b1, 5'd0, 1'b0, 32'd2, 32'd3, 32'd0);
    // flush wins over stall
    vec(1'b0, 1'b1, 1'b1, 32'h0000_4180, 32'h2222_2222, 1'b1, 1'b1, 32'h0000_4180, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 32'd2, 32'd3, 32'd0);
    // misaligned, above limit, below base, then limit itself
    vec(1'b0, 1'b0, 1'b0, 32'h0000_3002, 32'h3333_3333, 1'b0, 1'b1, 32'h0000_3002, 32'h0000_0000, 1'b1, 5'd4, 1'b0, 32'd2, 32'd3, 32'd1);
    vec(1'b0, 1'b0, 1'b0, 32'h0000_7000, 32'hxxxx_xxxx, 1'b0, 1'b1, 32'h0000_7000, 32'h0000_0000, 1'b1, 5'd4, 1'b0, 32'd2, 32'd3, 32'd2);
    vec(1'b0, 1'b0, 1'b0, 32'h0000_2FFC, 32'hxxxx_xxxx, 1'b0, 1'b1, 32'h0000_2FFC, 32'h0000_0000, 1'b1, 5'd4, 1'b0, 32'd2, 32'd3, 32'd3);
    vec(1'b0, 1'b0, 1'b0, 32'h0000_6FFC, 32'h4444_4444, 1'b0, 1'b1, 32'h0000_6FFC, 32'h4444_4444, 1'b1, 5'd0, 1'b0, 32'd3, 32'd3, 32'd3);
    // delay slot at IM_BASE, held through two stalls, cleared by flush
    vec(1'b0, 1'b0, 1'b0, 32'h0000_3000, 32'h5555_5555, 1'b1, 1'b1, 32'h0000_3000, 32'h5555_5555, 1'b1, 5'd0, 1'b1, 32'd4, 32'd3, 32'd3);
    vec(1'b0, 1'b1, 1'b0, 32'h0000_3004, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_3000, 32'h5555_5555, 1'b1, 5'd0, 1'b1, 32'd4, 32'd4, 32'd3);
    vec(1'b0, 1'b1, 1'b0, 32'h0000_3004, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_3000, 32'h5555_5555, 1'b1, 5'd0, 1'b1, 32'd4, 32'd5, 32'd3);
    vec(1'b0, 1'b0, 1'b1, 32'h0000_5000, 32'h9999_9999, 1'b1, 1'b1, 32'h0000_5000, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 32'd4, 32'd5, 32'd3);
    vec(1'b0, 1'b0, 1'b0, 32'h0000_5000, 32'h6666_6666, 1'b0, 1'b1, 32'h0000_5000, 32'h6666_6666, 1'b1, 5'd0, 1'b0, 32'd5, 32'd5, 32'd3);
    // reset during a stall, then a normal load
    vec(1'b1, 1'b1, 1'b0, 32'h0000_3010, 32'h7777_7777, 1'b1, 1'b0, 32'h0000_3000, 32'h0000_0000, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
    vec(1'b0, 1'b0, 1'b0, 32'h0000_3010, 32'h7777_7777, 1'b1, 1'b1, 32'h0000_3010, 32'h7777_7777, 1'b1, 5'd0, 1'b1, 32'd1, 32'd0, 32'd0);
    // misaligned fetch in a delay slot keeps the bd flag
    vec(1'b0, 1'b0, 1'b0, 32'h0000_6FFE, 32'h8888_8888, 1'b1, 1'b1, 32'h0000_6FFE, 32'h0000_0000, 1'b1, 5'd4, 1'b1, 32'd1, 32'd0, 32'd1);
    // IM_LIMIT+4 faults
    vec(1'b0, 1'b0, 1'b0, 32'h0000_7000, 32'h8888_8888, 1'b0, 1'b1, 32'h0000_7000, 32'h0000_0000, 1'b1, 5'd4, 1'b0, 32'd1, 32'd0, 32'd2);

    // Saturation: preload stall_cnt just below all-ones, stall three edges.
    @(negedge clk);
    stall = 1'b1;
    flush = 1'b0;
    force dut.stall_cnt_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.stall_cnt_q;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("stall_cnt_sat", 0, stall_cnt, 32'hFFFF_FFFF);
    check("id_pc_sat_hold", 0, id_pc, 32'h0000_7000);
    check("fault_cnt_sat_hold", 0, fault_cnt, 32'd2);

    @(negedge clk);
    stall = 1'b0;
    check("queue_drained", 0, exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline boundary, directly downstream of the PC register.
- Samples the fetched PC and instruction each cycle.
- Generates the PC write-enable.
- Detects instruction-fetch address faults and inserts bubbles on flush.
- Keeps fetch performance counters readable by debug logic.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded into id_pc on reset.
- IM_BASE, 32'h0000_3000, lowest legal instruction address.
- IM_LIMIT, 32'h0000_6FFC, highest legal instruction address (inclusive).
- NOP_INSTR, 32'h0000_0000, encoding inserted for bubbles and faulted fetches.
- EXC_ADEL, 5'd4, exception code for a bad fetch address.

Ports:
- clk  in  1  clock.
- reset  in  1  reset: synchronous, active-high. Clock is clk.
- stall  in  1  hazard-unit stall request; holds IF and ID.
- flush  in  1  kill the instruction entering ID (exception/eret redirect).
- if_pc  in  32  current PC from the PC register.
- if_instr  in  32  instruction-memory read data at if_pc (combinational).
- if_bd  in  1  high when the IF instruction is a branch delay slot.
- pc_en  out  1  enable to the PC register.
- id_pc  out  32  registered PC of the ID instruction.
- id_instr  out  32  registered instruction.
- id_valid  out  1  ID holds a real (non-bubble) instruction.
- id_excode  out  5  exception code carried into ID; 0 = none.
- id_bd  out  1  registered delay-slot flag.
- fetch_cnt  out  32  good instructions loaded into ID.
- stall_cnt  out  32  cycles spent stalled.
- fault_cnt  out  32  faulted fetches loaded into ID.

Behaviour:
- All registers update on posedge clk only. No async paths.
- pc_en = ~stall | flush (combinational). Flush must let the PC take the redirect even during a stall.
- fault = (if_pc[1:0] != 0) | (if_pc < IM_BASE) | (if_pc > IM_LIMIT). Comparisons are unsigned 32-bit. Combinational, internal.
- Per-cycle priority is reset > flush > stall > load.
- Reset values:
  - id_pc = RESET_PC.
  - id_instr = NOP_INSTR.
  - id_valid = 0, id_excode = 0, id_bd = 0.
  - All counters = 0.
- Flush (wins over stall):
  - id_instr = NOP_INSTR, id_valid = 0, id_excode = 0, id_bd = 0.
  - id_pc <= if_pc.
  - Counters unchanged.
- Stall (no flush):
  - All id_* hold.
  - stall_cnt += 1.
- Load, good fetch (no reset/flush/stall, fault = 0):
  - id_pc <= if_pc, id_instr <= if_instr, id_valid <= 1, id_excode <= 0, id_bd <= if_bd.
  - fetch_cnt += 1.
- Load, faulted fetch (fault = 1):
  - id_pc <= if_pc, id_instr <= NOP_INSTR, id_valid <= 1, id_excode <= EXC_ADEL, id_bd <= if_bd.
  - fault_cnt += 1.
  - if_instr is ignored, even if X.
- Latency: an IF value appears on the id_* outputs exactly 1 cycle after the loading edge.
- Counters saturate at 32'hFFFF_FFFF and never wrap.
- Reset during a stall or flush: reset values apply on that edge. The next non-stalled edge loads normally.
- Back-to-back stalls: the held id_* values are bit-identical across all stalled cycles.
- Stall released: the first load edge captures whatever if_pc/if_instr present then (the PC was held, so this is the same address).
- Boundary addresses IM_BASE and IM_LIMIT are legal. IM_LIMIT+4 and IM_BASE-4 fault.

Test Plan:
- Reset held 2 cycles, then released with if_pc=3000, if_instr=24010005 -> after reset: id_pc=3000, id_valid=0, counters 0. One edge later: id_instr=24010005, id_valid=1, fetch_cnt=1.
- Stall high for 3 cycles with id holding pc 3004 -> pc_en=0; id_pc=3004 and id_instr unchanged all 3 cycles; stall_cnt=3.
- stall=1 and flush=1 on the same edge with if_pc=4180 -> pc_en=1; next cycle id_pc=4180, id_valid=0, id_instr=0, stall_cnt unchanged.
- if_pc=3002, then 7000, then 2FFC, then 6FFC -> first three give id_excode=4, id_instr=0, id_valid=1. 6FFC gives excode 0. fault_cnt=3, fetch_cnt=1.
- if_bd=1 loaded, then a stall -> id_bd=1 held through the stall. A following flush clears it to 0.
- Preload stall_cnt near saturation by forcing FFFF_FFFE, then stall 3 cycles -> ends at FFFF_FFFF, no wrap.
